// File: rtl/sram_controller_pkg.sv
// Shared definitions for the half-word SRAM sequencer: FSM states, pad width,
// default address map and the wait-counter width helper.
package sram_controller_pkg;

  localparam int SRAM_DW           = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

  // One 32-bit access is two bus phases (low half, then high half) plus a
  // completion cycle in which the pipeline is released.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counter width for 0..waits, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned waits);
    return (waits < 1) ? 1 : $clog2(waits + 1);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Bundle of the MEM-stage request/response signals and the SRAM pad signals.
// The controller uses the slave view; the pipeline/pad environment the master view.
interface sram_controller_if #(
  parameter int unsigned SRAM_AW = 18
);
  import sram_controller_pkg::*;

  logic                 wr_en;
  logic                 rd_en;
  logic [31:0]          address;
  logic [31:0]          write_data;
  logic [31:0]          read_data;
  logic                 ready;
  logic [SRAM_AW-1:0]   sram_addr;
  logic [SRAM_DW-1:0]   sram_dq_out;
  logic                 sram_dq_oe;
  logic [SRAM_DW-1:0]   sram_dq_in;
  logic                 sram_we_n;
  logic                 sram_oe_n;
  logic                 sram_ce_n;
  logic                 sram_ub_n;
  logic                 sram_lb_n;

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Wait-state counter for one half-word bus phase: counts 0..WAIT_CYCLES and
// flags the final cycle of the phase.
module sram_wait_counter
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic advance_i,
  output logic last_o
);

  localparam int unsigned   CW      = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o = (cnt_q == CNT_MAX);

  // Load restarts the count for a fresh phase; advance steps through waits.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (advance_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two half-word phases (low first) with programmable wait states. ready low
// freezes the pipeline until the access reaches its completion cycle.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18,
  parameter logic [31:0] BASE_ADDR   = 32'(DEFAULT_BASE_ADDR)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sram_controller_if.slave bus
);

  state_e             state_q, state_d;
  logic               op_write_q, op_write_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;

  logic               req;
  logic               in_phase;
  logic               phase_last;
  logic [SRAM_AW-2:0] req_word;

  assign req      = bus.wr_en | bus.rd_en;
  assign in_phase = (state_q == ST_LO) || (state_q == ST_HI);
  assign req_word = (SRAM_AW-1)'((bus.address - BASE_ADDR) >> 2);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (!in_phase || phase_last),
    .advance_i(in_phase),
    .last_o   (phase_last)
  );

  // State register; reset drops any access in flight back to IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: requests are only looked at in IDLE; phases end on the last wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req)        state_d = ST_LO;
      ST_LO:   if (phase_last) state_d = ST_HI;
      ST_HI:   if (phase_last) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch the request on accept, step the half-word
  // address between phases and gather load halves on each phase's last cycle.
  always_comb begin
    op_write_d  = op_write_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    if (state_q == ST_IDLE && req) begin
      op_write_d  = bus.wr_en;
      word_d      = req_word;
      wdata_d     = bus.write_data;
      sram_addr_d = {req_word, 1'b0};
    end
    if (state_q == ST_LO && phase_last) begin
      sram_addr_d = {word_q, 1'b1};
      if (!op_write_q) rdata_d[15:0] = bus.sram_dq_in;
    end
    if (state_q == ST_HI && phase_last && !op_write_q) begin
      rdata_d[31:16] = bus.sram_dq_in;
    end
  end

  // Datapath registers; read_data and the SRAM address hold between accesses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      op_write_q  <= op_write_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  // Output decode: strobes are active only during LO/HI and forced idle
  // while reset is held so an aborted access stops touching the bus at once.
  always_comb begin
    bus.ready       = rst_ni && (((state_q == ST_IDLE) && !req) || (state_q == ST_DONE));
    bus.read_data   = rdata_q;
    bus.sram_addr   = sram_addr_q;
    bus.sram_we_n   = 1'b1;
    bus.sram_oe_n   = 1'b1;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_dq_out = '0;
    bus.sram_ce_n   = !rst_ni;
    bus.sram_ub_n   = !rst_ni;
    bus.sram_lb_n   = !rst_ni;
    if (rst_ni && in_phase) begin
      if (op_write_q) begin
        bus.sram_we_n   = 1'b0;
        bus.sram_dq_oe  = 1'b1;
        bus.sram_dq_out = (state_q == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        bus.sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: one instance with one wait state and one with
// none, each wired to a small behavioural SRAM. Expected results come from a
// word-level memory model and the latency formula 2*(waits+1)+1.
module tb_sram_controller;

  localparam int unsigned AW   = 18;
  localparam int          BASE = 1024;

  typedef struct {
    bit          s;
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    bit          drop;
    logic [31:0] expRd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sel;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] addrIn;
  logic [31:0] dataIn;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] memA [512];
  logic [15:0] memB [512];
  logic [31:0] refMem [2][256];
  logic [31:0] lastLoad [2];

  sram_controller_if #(.SRAM_AW(AW)) ifA ();
  sram_controller_if #(.SRAM_AW(AW)) ifB ();

  sram_controller #(.WAIT_CYCLES(1), .SRAM_AW(AW), .BASE_ADDR(32'd1024)) dutA (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (ifA)
  );

  sram_controller #(.WAIT_CYCLES(0), .SRAM_AW(AW), .BASE_ADDR(32'd1024)) dutB (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (ifB)
  );

  // Free-running pipeline clock.
  always #5 clk = ~clk;

  // Route the shared request drivers to whichever instance is selected.
  assign ifA.wr_en      = wrEn & ~sel;
  assign ifA.rd_en      = rdEn & ~sel;
  assign ifB.wr_en      = wrEn & sel;
  assign ifB.rd_en      = rdEn & sel;
  assign ifA.address    = addrIn;
  assign ifB.address    = addrIn;
  assign ifA.write_data = dataIn;
  assign ifB.write_data = dataIn;

  // Asynchronous SRAM read path: data appears only while output-enabled.
  assign ifA.sram_dq_in = ifA.sram_oe_n ? 16'h0000 : memA[ifA.sram_addr[8:0]];
  assign ifB.sram_dq_in = ifB.sram_oe_n ? 16'h0000 : memB[ifB.sram_addr[8:0]];

  // SRAM write path: a selected, write-enabled, driven pad stores the half-word.
  always @(posedge clk) begin
    if (!ifA.sram_ce_n && !ifA.sram_we_n && ifA.sram_dq_oe) memA[ifA.sram_addr[8:0]] = ifA.sram_dq_out;
    if (!ifB.sram_ce_n && !ifB.sram_we_n && ifB.sram_dq_oe) memB[ifB.sram_addr[8:0]] = ifB.sram_dq_out;
  end

  // Observation view of the selected instance.
  logic          curReady, curWeN, curOeN, curDqOe;
  logic [15:0]   curDqOut;
  logic [AW-1:0] curAddr;
  logic [31:0]   curRd;
  assign curReady = sel ? ifB.ready       : ifA.ready;
  assign curWeN   = sel ? ifB.sram_we_n   : ifA.sram_we_n;
  assign curOeN   = sel ? ifB.sram_oe_n   : ifA.sram_oe_n;
  assign curDqOe  = sel ? ifB.sram_dq_oe  : ifA.sram_dq_oe;
  assign curDqOut = sel ? ifB.sram_dq_out : ifA.sram_dq_out;
  assign curAddr  = sel ? ifB.sram_addr   : ifA.sram_addr;
  assign curRd    = sel ? ifB.read_data   : ifA.read_data;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one request and follow it until ready returns (bounded), recording
  // latency, strobe cycle counts and any deviation from the expected bus phases.
  task automatic applyStimulus(input bit s, input bit w, input bit r,
                               input logic [31:0] a, input logic [31:0] d, input bit drop,
                               output int lat, output int weCnt, output int oeCnt, output int busErr);
    int waits;
    int hwLo;
    int ph;
    logic [15:0] expDq;
    waits = s ? 0 : 1;
    hwLo  = int'((a - 32'd1024) >> 2) * 2;
    @(negedge clk);
    sel = s; wrEn = w; rdEn = r; addrIn = a; dataIn = d;
    #1;
    lat = 0; weCnt = 0; oeCnt = 0; busErr = 0;
    while (curReady !== 1'b1 && lat < 20) begin
      if (lat >= 1) begin
        ph    = (lat <= waits + 1) ? 0 : 1;
        expDq = ph ? d[31:16] : d[15:0];
        if (curAddr !== AW'(hwLo + ph)) busErr++;
        if (w) begin
          if (curDqOut !== expDq || curDqOe !== 1'b1) busErr++;
        end else if (curDqOe !== 1'b0) begin
          busErr++;
        end
      end
      if (curWeN === 1'b0) weCnt++;
      if (curOeN === 1'b0) oeCnt++;
      @(negedge clk);
      if (drop) begin
        wrEn = 1'b0; rdEn = 1'b0; addrIn = $urandom; dataIn = $urandom;
      end
      #1;
      lat++;
    end
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  // One full transaction with all of its checks, then advance the word model.
  task automatic runVector(input bit s, input bit w, input bit r,
                           input logic [31:0] a, input logic [31:0] d, input bit drop,
                           input logic [31:0] expRd, input string tag);
    int lat, weCnt, oeCnt, busErr, waits, word;
    waits = s ? 0 : 1;
    word  = int'((a - 32'd1024) >> 2);
    applyStimulus(s, w, r, a, d, drop, lat, weCnt, oeCnt, busErr);
    checkOutput({tag, " latency"}, 32'(lat), 32'(2 * (waits + 1) + 1));
    checkOutput({tag, " weCycles"}, 32'(weCnt), w ? 32'(2 * (waits + 1)) : 32'd0);
    checkOutput({tag, " oeCycles"}, 32'(oeCnt), (!w && r) ? 32'(2 * (waits + 1)) : 32'd0);
    checkOutput({tag, " busPhase"}, 32'(busErr), 32'd0);
    checkOutput({tag, " readData"}, curRd, expRd);
    if (w) refMem[s][word] = d;
    else   lastLoad[s] = refMem[s][word];
  endtask

  vec_t vecs [10];

  // Main sequence: reset checks, directed table, reset abort, random traffic.
  initial begin
    vecs[0] = '{0, 1, 0, 32'd1024, 32'hDEADBEEF, 0, 32'h00000000};
    vecs[1] = '{0, 0, 1, 32'd1028, 32'h0,        0, 32'h12345678};
    vecs[2] = '{0, 0, 1, 32'd1024, 32'h0,        0, 32'hDEADBEEF};
    vecs[3] = '{1, 1, 0, 32'd1064, 32'hCAFEF00D, 0, 32'h00000000};
    vecs[4] = '{1, 0, 1, 32'd1064, 32'h0,        0, 32'hCAFEF00D};
    vecs[5] = '{0, 1, 1, 32'd1032, 32'hA5A55A5A, 0, 32'hDEADBEEF};
    vecs[6] = '{0, 0, 1, 32'd1032, 32'h0,        0, 32'hA5A55A5A};
    vecs[7] = '{0, 1, 0, 32'd1036, 32'h01234567, 1, 32'hA5A55A5A};
    vecs[8] = '{0, 0, 1, 32'd1036, 32'h0,        0, 32'h01234567};
    vecs[9] = '{0, 0, 1, 32'd1031, 32'h0,        0, 32'h12345678};

    for (int s = 0; s < 2; s++) begin
      for (int wd = 0; wd < 256; wd++) refMem[s][wd] = $urandom;
      lastLoad[s] = 32'h0;
    end
    refMem[0][1] = 32'h12345678;
    for (int wd = 0; wd < 256; wd++) begin
      memA[2*wd]   = refMem[0][wd][15:0];
      memA[2*wd+1] = refMem[0][wd][31:16];
      memB[2*wd]   = refMem[1][wd][15:0];
      memB[2*wd+1] = refMem[1][wd][31:16];
    end

    rstN = 1'b0; sel = 1'b0; wrEn = 1'b0; rdEn = 1'b0; addrIn = 32'd1024; dataIn = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset ready",    32'(ifA.ready),      32'd0);
    checkOutput("reset we_n",     32'(ifA.sram_we_n),  32'd1);
    checkOutput("reset oe_n",     32'(ifA.sram_oe_n),  32'd1);
    checkOutput("reset ce_n",     32'(ifA.sram_ce_n),  32'd1);
    checkOutput("reset dq_oe",    32'(ifA.sram_dq_oe), 32'd0);
    checkOutput("reset addr",     32'(ifA.sram_addr),  32'd0);
    checkOutput("reset readData", ifA.read_data,       32'd0);
    rstN = 1'b1;
    @(negedge clk); #1;
    checkOutput("post-reset ready", 32'(ifA.ready),     32'd1);
    checkOutput("post-reset ce_n",  32'(ifA.sram_ce_n), 32'd0);

    for (int i = 0; i < 10; i++) begin
      runVector(vecs[i].s, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].drop,
                vecs[i].expRd, $sformatf("vec%0d", i));
    end

    // Reset asserted during the high-half phase of a store to word 200.
    @(negedge clk);
    sel = 1'b0; wrEn = 1'b1; addrIn = 32'(BASE + 800); dataIn = 32'h11112222;
    #1;
    @(negedge clk); wrEn = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("abort HI addr", 32'(ifA.sram_addr), 32'd401);
    checkOutput("abort HI we_n", 32'(ifA.sram_we_n), 32'd0);
    rstN = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort we_n",     32'(ifA.sram_we_n),  32'd1);
    checkOutput("abort dq_oe",    32'(ifA.sram_dq_oe), 32'd0);
    checkOutput("abort ready",    32'(ifA.ready),      32'd0);
    checkOutput("abort readData", ifA.read_data,       32'd0);
    @(negedge clk); #1;
    checkOutput("abort idle we_n", 32'(ifA.sram_we_n), 32'd1);
    checkOutput("abort idle oe_n", 32'(ifA.sram_oe_n), 32'd1);
    rstN = 1'b1;
    @(negedge clk); #1;
    checkOutput("abort release ready", 32'(ifA.ready), 32'd1);
    lastLoad[0] = 32'h0;
    lastLoad[1] = 32'h0;

    for (int i = 0; i < 40; i++) begin
      bit          s, w, r, drop;
      int          kind, word;
      logic [31:0] a, d, expRd;
      s    = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      w    = (kind != 1);
      r    = (kind != 0);
      word = int'($urandom_range(0, 127));
      a    = 32'(BASE + word * 4) + 32'($urandom_range(0, 3));
      d    = $urandom;
      drop = 1'($urandom_range(0, 1));
      expRd = w ? lastLoad[s] : refMem[s][word];
      runVector(s, w, r, a, d, drop, expRd, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
